stream_mux_4_to_1: RTL and testbench
====================================

# stream_mux_4_to_1

Merges four independent valid/ready input streams onto one output stream using round-robin arbitration with packet locking, tagging each output beat with the 2-bit index of its source channel. It is the gathering counterpart of the 1-to-4 demultiplexer: the demux fans one stream out by `sel`; this block fans four streams back in and regenerates `sel` as `out_sel`. It has a single registered output stage, giving 1-cycle latency at full throughput.

## Interface
- `WIDTH`, default 8: data width per channel.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  4  per-channel valid; bit i belongs to channel i.
- `in_data`  input  4*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_last`  input  4  per-channel end-of-packet flag.
- `in_ready`  output  4  per-channel ready; combinational.
- `out_valid`  output  1  output beat valid; registered.
- `out_data`  output  WIDTH  output data; registered.
- `out_last`  output  1  end-of-packet flag of the output beat; registered.
- `out_sel`  output  2  source channel index of the output beat; registered.
- `out_ready`  input  1  downstream accept.

## Operation
- A transfer on channel i occurs when `in_valid[i] && in_ready[i]` at a clock edge. An output transfer occurs when `out_valid && out_ready`.
- `can_load = !out_valid || out_ready`. This means the output register is empty, or it drains in the same cycle.
- At most one bit of `in_ready` is high. `in_ready[i] = can_load && grant[i]`. `grant` is one-hot and depends combinationally on `in_valid`, the state, `owner` and `last_grant`.
- The state machine has two states, ARB and LOCK. It also holds a 2-bit `owner` register and a 2-bit `last_grant` register.
- ARB state:
  - `grant` selects the first channel with `in_valid` set, searching in the order `last_grant+1`, `+2`, `+3`, `+0` (mod 4).
  - On a transfer with `in_last=1`: stay in ARB and set `last_grant` to the granted channel.
  - On a transfer with `in_last=0`: go to LOCK and set `owner` to the granted channel.
- LOCK state:
  - `grant[owner] = in_valid[owner]`; all other channels are blocked even if valid.
  - On an owner transfer with `in_last=1`: go to ARB and set `last_grant = owner`.
- On any input transfer, the output register loads `{data, last, sel}` of the granted channel and sets `out_valid=1`.
- If an output transfer occurs with no input transfer in the same cycle, `out_valid` clears to 0.
- Simultaneous output drain and input load in one cycle is legal: `out_valid` stays 1 and the output register takes the new beat.
- While `out_valid && !out_ready`: all `in_ready` are 0, and `out_data`, `out_last` and `out_sel` hold stable.
- Idle cycles inside a locked packet (owner not valid) do not release the lock.

## Timing
- Reset (async assert, sync release) sets: `out_valid=0`, `out_data=0`, `out_last=0`, `out_sel=0`, state=ARB, `owner=0`, `last_grant=3`.
  - Consequence: channel 0 has highest priority on the first arbitration.
- During reset `in_ready` is 0.
- A reset asserted mid-packet abandons the packet. After release the block is in ARB with no lock.
- Latency: an input transfer at edge N gives `out_valid=1` after edge N.
- Throughput: one beat per cycle when `out_ready` is held high.
- Arbitration switches channels with zero bubble cycles. A packet ending at edge N lets a different channel transfer at edge N+1.
- Fairness: with all four channels continuously valid and single-beat packets, grants rotate 0,1,2,3,0,…

## Test plan
- **Single channel:** after reset, channel 2 sends one beat, data 0x5A, last=1, with `out_ready=1`.
  - Required: `in_ready=4'b0100` in that cycle; the next cycle shows `out_valid=1`, `out_data=0x5A`, `out_sel=2`, `out_last=1`.
- **Round robin:** all four channels valid with single-beat packets (`in_last=1`), `out_ready=1`, for 8 cycles.
  - Required: `out_sel` sequence is 0,1,2,3,0,1,2,3 and `out_valid` stays 1 throughout.
- **Packet lock:**
  - Stimulus: channel 1 sends a 3-beat packet 0x11, 0x12, 0x13 (last on the third beat). Channel 0 is valid throughout. Channel 1 drops valid for one cycle mid-packet.
  - Required: output is 0x11, 0x12, 0x13 from channel 1 with no channel-0 beat interleaved; the channel-0 beat follows immediately after.
- **Backpressure:** `out_ready=0` for 3 cycles while channels 0 and 3 are valid.
  - Required: all `in_ready` stay 0 after the first load, and the output holds its first beat stable.
  - Required: after `out_ready` returns to 1, the next beat comes from the other channel on the cycle the first beat drains.
- **Reset mid-packet:** assert `rst_n=0` after beat 2 of a 4-beat packet on channel 3.
  - Required: outputs go to zero immediately (asynchronously).
  - Required: after release, channel 0 wins when channels 0 and 3 are both valid.
- **Drain plus load:** `out_valid=1` and `out_ready=1` with channel 1 valid.
  - Required: `out_valid` stays 1 and the new beat replaces the old one in the same edge, with no gap.

Source files
------------

// File: rtl/stream_mux_4_to_1.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_4_to_1
// Brief    : Round-robin 4:1 valid/ready stream merge with packet locking;
//            each output beat is tagged with its source channel index.
// Revision : 1.0
// ============================================================================
module stream_mux_4_to_1 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         i_in_valid,
    input  logic [4*WIDTH-1:0] i_in_data,
    input  logic [3:0]         i_in_last,
    output logic [3:0]         o_in_ready,
    output logic               o_out_valid,
    output logic [WIDTH-1:0]   o_out_data,
    output logic               o_out_last,
    output logic [1:0]         o_out_sel,
    input  logic               i_out_ready
);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_owner;
    logic [1:0]       r_last_grant;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic [1:0]       r_out_sel;

    logic [WIDTH-1:0] w_ch_data [4];
    logic             w_found;
    logic [1:0]       w_sel;
    logic [1:0]       w_cand;
    logic [3:0]       w_grant;
    logic             w_can_load;
    logic             w_xfer;
    logic             w_sel_last;

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        assign w_ch_data[g] = i_in_data[g*WIDTH +: WIDTH];
    end

    // Search starts just after the last winner, so the most recent winner
    // has the lowest priority on the next arbitration.
    always_comb begin
        w_found = 1'b0;
        w_sel   = 2'd0;
        w_cand  = 2'd0;
        if (r_state == ST_LOCK) begin
            w_found = i_in_valid[r_owner];
            w_sel   = r_owner;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                w_cand = r_last_grant + 2'(k);
                if (!w_found && i_in_valid[w_cand]) begin
                    w_found = 1'b1;
                    w_sel   = w_cand;
                end
            end
        end
    end

    assign w_grant    = w_found ? (4'b0001 << w_sel) : 4'b0000;
    assign w_can_load = !r_out_valid || i_out_ready;
    // rst_n gates the handshake so no channel sees ready while in reset.
    assign w_xfer     = w_found && w_can_load && rst_n;
    assign o_in_ready = w_xfer ? w_grant : 4'b0000;
    assign w_sel_last = i_in_last[w_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_ARB;
            r_owner      <= 2'd0;
            r_last_grant <= 2'd3;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_out_sel    <= 2'd0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_ch_data[w_sel];
                r_out_last  <= w_sel_last;
                r_out_sel   <= w_sel;
                case (r_state)
                    ST_ARB: begin
                        if (w_sel_last) begin
                            r_last_grant <= w_sel;
                        end else begin
                            r_state <= ST_LOCK;
                            r_owner <= w_sel;
                        end
                    end
                    ST_LOCK: begin
                        if (w_sel_last) begin
                            r_state      <= ST_ARB;
                            r_last_grant <= r_owner;
                        end
                    end
                    default: r_state <= ST_ARB;
                endcase
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;
    assign o_out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_4_to_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_4_to_1
// Brief    : Directed self-checking bench for stream_mux_4_to_1.
// Revision : 1.0
// ============================================================================
module tb_stream_mux_4_to_1;

    localparam int c_W = 8;

    logic           clk;
    logic           rst_n;
    logic [3:0]     i_in_valid;
    logic [4*c_W-1:0] i_in_data;
    logic [3:0]     i_in_last;
    logic [3:0]     o_in_ready;
    logic           o_out_valid;
    logic [c_W-1:0] o_out_data;
    logic           o_out_last;
    logic [1:0]     o_out_sel;
    logic           i_out_ready;

    int checks;
    int failures;

    stream_mux_4_to_1 #(.WIDTH(c_W)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
        .i_in_last   (i_in_last),
        .o_in_ready  (o_in_ready),
        .o_out_valid (o_out_valid),
        .o_out_data  (o_out_data),
        .o_out_last  (o_out_last),
        .o_out_sel   (o_out_sel),
        .i_out_ready (i_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        i_in_valid  = 4'b0000;
        i_in_data   = '0;
        i_in_last   = 4'b0000;
        i_out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n      = 1'b0;
        i_in_valid = 4'b1111;
        #1;
        checks++;
        if (o_in_ready !== 4'b0000) begin
            failures++; $display("FAIL reset_in_ready: got %b want 0000", o_in_ready);
        end
        checks++;
        if ({o_out_valid, o_out_data, o_out_last, o_out_sel} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b s=%0d want all 0",
                     o_out_valid, o_out_data, o_out_last, o_out_sel);
        end
        i_in_valid = 4'b0000;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        i_in_valid          = 4'b0100;
        i_in_data[2*c_W +: c_W] = 8'h5A;
        i_in_last           = 4'b1111;
        #1;
        checks++;
        if (o_in_ready !== 4'b0100) begin
            failures++; $display("FAIL single_in_ready: got %b want 0100", o_in_ready);
        end
        step();
        i_in_valid = 4'b0000;
        checks++;
        if ({o_out_valid, o_out_data, o_out_sel, o_out_last} !== {1'b1, 8'h5A, 2'd2, 1'b1}) begin
            failures++;
            $display("FAIL single_out: got v=%b d=%h s=%0d l=%b want v=1 d=5a s=2 l=1",
                     o_out_valid, o_out_data, o_out_sel, o_out_last);
        end
        step();
        checks++;
        if (o_out_valid !== 1'b0) begin
            failures++; $display("FAIL single_drain: got valid=%b want 0", o_out_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) i_in_data[i*c_W +: c_W] = 8'hA0 + 8'(i);
        i_in_last  = 4'b1111;
        i_in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (o_out_valid !== 1'b1 || o_out_sel !== 2'(k % 4) ||
                o_out_data !== 8'hA0 + 8'(k % 4)) begin
                failures++;
                $display("FAIL rr_beat%0d: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                         k, o_out_valid, o_out_sel, o_out_data, k % 4, 8'hA0 + 8'(k % 4));
            end
        end
        i_in_valid = 4'b0000;
        step();
    endtask

    task automatic test_packet_lock();
        logic [3:0]     v_valid [6];
        logic [7:0]     v_d1    [6];
        logic           v_l1    [6];
        logic           e_valid [6];
        logic [7:0]     e_data  [6];
        logic [1:0]     e_sel   [6];
        do_reset();
        // beat 0 moves last_grant to 0 so channel 1 wins next despite ch0 valid
        v_valid = '{4'b0001, 4'b0011, 4'b0011, 4'b0001, 4'b0011, 4'b0001};
        v_d1    = '{8'h00,   8'h11,   8'h12,   8'h00,   8'h13,   8'h00};
        v_l1    = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b1,    1'b0};
        e_valid = '{1'b1,    1'b1,    1'b1,    1'b0,    1'b1,    1'b1};
        e_data  = '{8'h01,   8'h11,   8'h12,   8'h12,   8'h13,   8'h0F};
        e_sel   = '{2'd0,    2'd1,    2'd1,    2'd1,    2'd1,    2'd0};
        for (int c = 0; c < 6; c++) begin
            i_in_valid = v_valid[c];
            i_in_data[0 +: c_W]   = (c == 0) ? 8'h01 : 8'h0F;
            i_in_data[c_W +: c_W] = v_d1[c];
            i_in_last = {2'b00, v_l1[c], 1'b1};
            if (c == 3) begin
                #1;
                checks++;
                if (o_in_ready !== 4'b0000) begin
                    failures++; $display("FAIL lock_block_ch0: got %b want 0000", o_in_ready);
                end
            end
            step();
            checks++;
            if (o_out_valid !== e_valid[c] ||
                (e_valid[c] && (o_out_data !== e_data[c] || o_out_sel !== e_sel[c]))) begin
                failures++;
                $display("FAIL lock_cycle%0d: got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                         c, o_out_valid, o_out_data, o_out_sel, e_valid[c], e_data[c], e_sel[c]);
            end
        end
        i_in_valid = 4'b0000;
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        i_in_data[0 +: c_W]     = 8'h30;
        i_in_data[3*c_W +: c_W] = 8'h33;
        i_in_last   = 4'b1111;
        i_in_valid  = 4'b1001;
        i_out_ready = 1'b0;
        #1;
        checks++;
        if (o_in_ready !== 4'b0001) begin
            failures++; $display("FAIL bp_first_ready: got %b want 0001", o_in_ready);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_in_ready !== 4'b0000 || o_out_valid !== 1'b1 ||
                o_out_data !== 8'h30 || o_out_sel !== 2'd0) begin
                failures++;
                $display("FAIL bp_hold%0d: got r=%b v=%b d=%h s=%0d want r=0000 v=1 d=30 s=0",
                         i, o_in_ready, o_out_valid, o_out_data, o_out_sel);
            end
            step();
        end
        i_out_ready = 1'b1;
        #1;
        checks++;
        if (o_in_ready !== 4'b1000) begin
            failures++; $display("FAIL bp_release_ready: got %b want 1000", o_in_ready);
        end
        step();
        i_in_valid = 4'b0000;
        checks++;
        if (o_out_valid !== 1'b1 || o_out_data !== 8'h33 || o_out_sel !== 2'd3) begin
            failures++;
            $display("FAIL bp_second_beat: got v=%b d=%h s=%0d want v=1 d=33 s=3",
                     o_out_valid, o_out_data, o_out_sel);
        end
        step();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        i_in_valid = 4'b1000;
        i_in_last  = 4'b0000;
        i_in_data[3*c_W +: c_W] = 8'h31;
        step();
        i_in_data[3*c_W +: c_W] = 8'h32;
        step();
        checks++;
        if (o_out_valid !== 1'b1 || o_out_data !== 8'h32) begin
            failures++; $display("FAIL rm_beat2: got v=%b d=%h want v=1 d=32", o_out_valid, o_out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_out_valid, o_out_data, o_out_last, o_out_sel, o_in_ready} !== '0) begin
            failures++;
            $display("FAIL rm_async_clear: got v=%b d=%h l=%b s=%0d r=%b want all 0",
                     o_out_valid, o_out_data, o_out_last, o_out_sel, o_in_ready);
        end
        step();
        rst_n = 1'b1;
        i_in_valid = 4'b1001;
        i_in_last  = 4'b1111;
        i_in_data[0 +: c_W] = 8'h40;
        #1;
        checks++;
        if (o_in_ready !== 4'b0001) begin
            failures++; $display("FAIL rm_after_ready: got %b want 0001", o_in_ready);
        end
        step();
        i_in_valid = 4'b0000;
        checks++;
        if (o_out_sel !== 2'd0 || o_out_data !== 8'h40 || o_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rm_after_beat: got v=%b s=%0d d=%h want v=1 s=0 d=40",
                     o_out_valid, o_out_sel, o_out_data);
        end
        step();
    endtask

    task automatic test_drain_load();
        do_reset();
        i_in_last  = 4'b1111;
        i_in_valid = 4'b0010;
        i_in_data[c_W +: c_W] = 8'h51;
        step();
        i_in_data[c_W +: c_W] = 8'h52;
        #1;
        checks++;
        if (o_in_ready !== 4'b0010 || o_out_data !== 8'h51) begin
            failures++;
            $display("FAIL dl_ready: got r=%b d=%h want r=0010 d=51", o_in_ready, o_out_data);
        end
        step();
        i_in_valid = 4'b0000;
        checks++;
        if (o_out_valid !== 1'b1 || o_out_data !== 8'h52 || o_out_sel !== 2'd1) begin
            failures++;
            $display("FAIL dl_replace: got v=%b d=%h s=%0d want v=1 d=52 s=1",
                     o_out_valid, o_out_data, o_out_sel);
        end
        step();
        checks++;
        if (o_out_valid !== 1'b0) begin
            failures++; $display("FAIL dl_empty: got v=%b want 0", o_out_valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_reset_mid_packet();
        test_drain_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
